// File: rtl/i_memory_if.sv
// EX/MEM-to-MEM bundle: EX/MEM register outputs in, branch/forwarding/MEM-WB outputs back.
interface i_memory_if;
    logic [1:0]  wb_ctl;
    logic [2:0]  m_ctl;
    logic [31:0] branch_target;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] wdata;
    logic [4:0]  dest_reg;

    logic        pcsrc;
    logic [31:0] pc_branch;
    logic [31:0] mem_alu_result;
    logic [4:0]  mem_dest_reg;
    logic        mem_regwrite;
    logic [1:0]  wb_ctlout;
    logic [31:0] read_data;
    logic [31:0] alu_result_out;
    logic [4:0]  dest_reg_out;
    logic        align_err;

    modport master (
        output wb_ctl, m_ctl, branch_target, zero, alu_result, wdata, dest_reg,
        input  pcsrc, pc_branch, mem_alu_result, mem_dest_reg, mem_regwrite,
        input  wb_ctlout, read_data, alu_result_out, dest_reg_out, align_err
    );

    modport slave (
        input  wb_ctl, m_ctl, branch_target, zero, alu_result, wdata, dest_reg,
        output pcsrc, pc_branch, mem_alu_result, mem_dest_reg, mem_regwrite,
        output wb_ctlout, read_data, alu_result_out, dest_reg_out, align_err
    );
endinterface

// File: rtl/i_memory.sv
// MIPS MEM stage: branch resolve, word data memory, MEM/WB register.
// Optional DMEM_ALIGN_CHK_EN: suppress misaligned accesses and raise sticky align_err.
module i_memory #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input logic        clk,
    input logic        rst,
    i_memory_if.slave  bus
);

    logic [31:0]       mem [DEPTH] = '{default: 32'h0};
    logic [ADDR_W-1:0] idx;
    logic [31:0]       mem_word;
    logic              mem_read;
    logic              mem_write;
    logic              misalign;

    assign idx       = bus.alu_result[ADDR_W+1:2];
    assign mem_word  = mem[idx];
    assign mem_read  = bus.m_ctl[1];
    assign mem_write = bus.m_ctl[0];

`ifdef DMEM_ALIGN_CHK_EN
    assign misalign = (mem_read | mem_write) & (bus.alu_result[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign bus.pcsrc          = bus.m_ctl[2] & bus.zero;
    assign bus.pc_branch      = bus.branch_target;
    assign bus.mem_alu_result = bus.alu_result;
    assign bus.mem_dest_reg   = bus.dest_reg;
    assign bus.mem_regwrite   = bus.wb_ctl[1];

    // Memory contents survive reset; only the write itself is blocked.
    always_ff @(posedge clk) begin
        if (!rst && mem_write && !misalign) begin
            mem[idx] <= bus.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.wb_ctlout      <= 2'b00;
            bus.read_data      <= 32'h0;
            bus.alu_result_out <= 32'h0;
            bus.dest_reg_out   <= 5'd0;
        end else begin
            bus.wb_ctlout      <= bus.wb_ctl;
            bus.read_data      <= (mem_read && !misalign) ? mem_word : 32'h0;
            bus.alu_result_out <= bus.alu_result;
            bus.dest_reg_out   <= bus.dest_reg;
        end
    end

`ifdef DMEM_ALIGN_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.align_err <= 1'b0;
        end else if (misalign) begin
            bus.align_err <= 1'b1;
        end
    end
`else
    assign bus.align_err = 1'b0;
`endif

endmodule

// File: tb/tb_i_memory.sv
// Bench for i_memory: directed vector table, reset/corner sequences, random run vs array model.
module tb_i_memory;

    localparam bit ALIGN =
`ifdef DMEM_ALIGN_CHK_EN
        1'b1;
`else
        1'b0;
`endif

    logic clk;
    logic rst;
    i_memory_if bus ();

    i_memory dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [31:0] ref_mem [256];
    logic [1:0]  ref_wb;
    logic [31:0] ref_rd;
    logic [31:0] ref_alu;
    logic [4:0]  ref_dest;
    logic        ref_align;

    typedef struct {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic        zero;
        logic [31:0] bt;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  dest;
        logic        exp_pcsrc;
        logic [31:0] exp_rd;
        logic [1:0]  exp_wb;
        logic [4:0]  exp_dest;
        logic        exp_align;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(logic [1:0] wb, logic [2:0] m, logic zero, logic [31:0] bt,
                                logic [31:0] alu, logic [31:0] wd, logic [4:0] dest,
                                logic exp_pcsrc, logic [31:0] exp_rd, logic exp_align);
        vec_t v;
        v.wb = wb; v.m = m; v.zero = zero; v.bt = bt; v.alu = alu; v.wd = wd; v.dest = dest;
        v.exp_pcsrc = exp_pcsrc; v.exp_rd = exp_rd; v.exp_wb = wb; v.exp_dest = dest;
        v.exp_align = exp_align;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One pipeline cycle: drive, check combinational paths, clock, check MEM/WB against model.
    task automatic step(input logic r, input logic [1:0] wb, input logic [2:0] m, input logic z,
                        input logic [31:0] bt, input logic [31:0] alu, input logic [31:0] wd,
                        input logic [4:0] dest);
        int  i;
        bit  mis;
        rst = r;
        bus.wb_ctl = wb; bus.m_ctl = m; bus.zero = z; bus.branch_target = bt;
        bus.alu_result = alu; bus.wdata = wd; bus.dest_reg = dest;
        #1;
        check("pcsrc", {31'h0, bus.pcsrc}, {31'h0, m[2] & z});
        check("pc_branch", bus.pc_branch, bt);
        check("mem_alu_result", bus.mem_alu_result, alu);
        check("mem_dest_reg", {27'h0, bus.mem_dest_reg}, {27'h0, dest});
        check("mem_regwrite", {31'h0, bus.mem_regwrite}, {31'h0, wb[1]});
        i   = int'(alu[9:2]);
        mis = ALIGN && (m[1] || m[0]) && (alu[1:0] != 2'b00);
        if (r) begin
            ref_wb = 0; ref_rd = 0; ref_alu = 0; ref_dest = 0; ref_align = 0;
        end else begin
            ref_wb   = wb;
            ref_rd   = (m[1] && !mis) ? ref_mem[i] : 32'h0;
            ref_alu  = alu;
            ref_dest = dest;
            if (m[0] && !mis) ref_mem[i] = wd;
            if (mis) ref_align = 1'b1;
        end
        @(posedge clk);
        #1;
        check("wb_ctlout", {30'h0, bus.wb_ctlout}, {30'h0, ref_wb});
        check("read_data", bus.read_data, ref_rd);
        check("alu_result_out", bus.alu_result_out, ref_alu);
        check("dest_reg_out", {27'h0, bus.dest_reg_out}, {27'h0, ref_dest});
        check("align_err", {31'h0, bus.align_err}, {31'h0, ref_align});
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  mr;
        for (int k = 0; k < 256; k++) ref_mem[k] = 32'h0;
        ref_wb = 0; ref_rd = 0; ref_alu = 0; ref_dest = 0; ref_align = 0;

        //                wb     m       z  bt      alu       wd           dest  pcsrc rd                             align
        tbl[0]  = mk(2'b00, 3'b010, 0, 32'h0,  32'h14,  32'h0,        5'd0, 0, 32'h0,                         0);
        tbl[1]  = mk(2'b00, 3'b001, 0, 32'h0,  32'h14,  32'hDEADBEEF, 5'd0, 0, 32'h0,                         0);
        tbl[2]  = mk(2'b11, 3'b010, 0, 32'h0,  32'h14,  32'h0,        5'd9, 0, 32'hDEADBEEF,                  0);
        tbl[3]  = mk(2'b00, 3'b100, 1, 32'h40, 32'h0,   32'h0,        5'd0, 1, 32'h0,                         0);
        tbl[4]  = mk(2'b00, 3'b100, 0, 32'h40, 32'h0,   32'h0,        5'd0, 0, 32'h0,                         0);
        tbl[5]  = mk(2'b00, 3'b001, 0, 32'h0,  32'h400, 32'h1234,     5'd0, 0, 32'h0,                         0);
        tbl[6]  = mk(2'b10, 3'b010, 0, 32'h0,  32'h0,   32'h0,        5'd3, 0, 32'h1234,                      0);
        tbl[7]  = mk(2'b00, 3'b001, 0, 32'h0,  32'hC,   32'hA,        5'd0, 0, 32'h0,                         0);
        tbl[8]  = mk(2'b11, 3'b011, 0, 32'h0,  32'hC,   32'hB,        5'd4, 0, 32'hA,                         0);
        tbl[9]  = mk(2'b11, 3'b010, 0, 32'h0,  32'hC,   32'h0,        5'd5, 0, 32'hB,                         0);
        tbl[10] = mk(2'b00, 3'b001, 0, 32'h0,  32'h22,  32'h55,       5'd0, 0, 32'h0,                         ALIGN);
        tbl[11] = mk(2'b10, 3'b010, 0, 32'h0,  32'h20,  32'h0,        5'd7, 0, ALIGN ? 32'h0 : 32'h55,        ALIGN);
        tbl[12] = mk(2'b00, 3'b000, 0, 32'h0,  32'h0,   32'h0,        5'd0, 0, 32'h0,                         ALIGN);
        tbl[13] = mk(2'b10, 3'b010, 0, 32'h0,  32'h22,  32'h0,        5'd8, 0, ALIGN ? 32'h0 : 32'h55,        ALIGN);

        rst = 1'b1;
        bus.wb_ctl = 0; bus.m_ctl = 0; bus.zero = 0; bus.branch_target = 0;
        bus.alu_result = 0; bus.wdata = 0; bus.dest_reg = 0;
        @(posedge clk);
        #1;

        // reset with random inputs and a store to word 5 that must be dropped
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 2'($urandom), 3'b001 | 3'($urandom), 1'($urandom), $urandom,
                 32'h14, $urandom, 5'($urandom));
        end

        for (int k = 0; k < 14; k++) begin
            step(1'b0, tbl[k].wb, tbl[k].m, tbl[k].zero, tbl[k].bt, tbl[k].alu, tbl[k].wd,
                 tbl[k].dest);
            check($sformatf("tbl%0d.pcsrc_seen", k), {31'h0, tbl[k].m[2] & tbl[k].zero},
                  {31'h0, tbl[k].exp_pcsrc});
            check($sformatf("tbl%0d.read_data", k), bus.read_data, tbl[k].exp_rd);
            check($sformatf("tbl%0d.wb_ctlout", k), {30'h0, bus.wb_ctlout}, {30'h0, tbl[k].exp_wb});
            check($sformatf("tbl%0d.dest_reg_out", k), {27'h0, bus.dest_reg_out},
                  {27'h0, tbl[k].exp_dest});
            check($sformatf("tbl%0d.align_err", k), {31'h0, bus.align_err},
                  {31'h0, tbl[k].exp_align});
        end

        // reset clears sticky flag but keeps memory
        step(1'b1, 2'b11, 3'b011, 1'b0, 32'h0, 32'h14, 32'h0BAD0BAD, 5'd1);
        check("rst_clears_align", {31'h0, bus.align_err}, 32'h0);
        step(1'b0, 2'b10, 3'b010, 1'b0, 32'h0, 32'h14, 32'h0, 5'd2);
        check("mem_survives_rst", bus.read_data, 32'hDEADBEEF);

        for (int k = 0; k < 400; k++) begin
            a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
            mr = 3'($urandom);
            step(($urandom_range(0, 29) == 0), 2'($urandom), mr, 1'($urandom), $urandom,
                 a, $urandom, 5'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
